// File: rtl/ex_stage_unit.sv
// ex_stage_unit: execute stage between ID/EX and EX/MEM.
// Computes the ALU result for one instruction per handshake and holds it, with
// the registered controls, in a single-entry EX/MEM slot.
// Optional multiplier: define EX_MUL_EN to build the iterative shift-add MUL.
// Without it, code 01010 is treated as unsupported (result 0, latency 1).
module ex_stage_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_to_reg,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             alu_src,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] sign_imm,
  input  logic [31:0]      pc_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] write_data,
  output logic             zero,
  output logic             mem_to_reg_q,
  output logic             mem_write_q,
  output logic             reg_write_q,
  output logic [31:0]      pc_target_q,
  output logic             busy
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;

  // Single-cycle ALU; every result wraps modulo 2^WIDTH, unknown codes give 0.
  function automatic logic [WIDTH-1:0] alu_op(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b,
                                               input logic [4:0]              op);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = $unsigned(a) << b[4:0];
      OP_SRL:  r = $unsigned(a) >> b[4:0];
      OP_SRA:  r = a >>> b[4:0];
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic signed [WIDTH-1:0] op_a_p0;
  logic signed [WIDTH-1:0] op_b_p0;
  logic        [WIDTH-1:0] res_p0;
  logic                    slot_free;
  logic                    accept;
  logic                    load_single;
  logic                    load_mul;
  logic        [WIDTH-1:0] nxt_res;
  logic        [WIDTH-1:0] nxt_wd;
  logic                    nxt_m2r;
  logic                    nxt_mw;
  logic                    nxt_rw;
  logic        [31:0]      nxt_pc;

  assign op_a_p0   = rd1;
  assign op_b_p0   = alu_src ? sign_imm : rd2;
  assign res_p0    = alu_op(op_a_p0, op_b_p0, alu_control);
  assign slot_free = !out_valid || out_ready;

`ifdef EX_MUL_EN
  localparam logic [4:0] OP_MUL = 5'b01010;
  localparam int         CNT_W  = $clog2(MUL_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, MUL_DONE = 2'd2} state_t;
  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_p1;
  logic [WIDTH-1:0] mul_a_p1;
  logic [WIDTH-1:0] mul_b_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0] mul_wd_p1;
  logic [31:0]      mul_pc_p1;
  logic             mul_m2r_p1;
  logic             mul_mw_p1;
  logic             mul_rw_p1;
  logic             is_mul;
  logic             mul_start;
  logic             last_iter;

  assign is_mul      = (alu_control == OP_MUL);
  assign in_ready    = !rst && (state_q == IDLE) && slot_free && !flush;
  assign accept      = in_valid && in_ready;
  assign mul_start   = accept && is_mul;
  assign load_single = accept && !is_mul;
  assign last_iter   = (cnt_p1 == CNT_W'(MUL_CYCLES - 1));
  assign load_mul    = (state_q == MUL_DONE) && slot_free && !flush;

  assign nxt_res = load_mul ? acc_p1     : res_p0;
  assign nxt_wd  = load_mul ? mul_wd_p1  : rd2;
  assign nxt_m2r = load_mul ? mul_m2r_p1 : mem_to_reg;
  assign nxt_mw  = load_mul ? mul_mw_p1  : mem_write;
  assign nxt_rw  = load_mul ? mul_rw_p1  : reg_write;
  assign nxt_pc  = load_mul ? mul_pc_p1  : pc_target;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and busy flag; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    busy    = !rst && (state_q == MUL_RUN);
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (mul_start) state_d = MUL_RUN;
        MUL_RUN:  if (last_iter) state_d = MUL_DONE;
        MUL_DONE: if (slot_free) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Shift-add multiplier: latch operands and controls at accept, then iterate.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_p1 <= '0;
      acc_p1 <= '0;
    end else if (mul_start) begin
      cnt_p1     <= '0;
      acc_p1     <= '0;
      mul_a_p1   <= op_a_p0;
      mul_b_p1   <= op_b_p0;
      mul_wd_p1  <= rd2;
      mul_pc_p1  <= pc_target;
      mul_m2r_p1 <= mem_to_reg;
      mul_mw_p1  <= mem_write;
      mul_rw_p1  <= reg_write;
    end else if (state_q == MUL_RUN) begin
      if (mul_b_p1[0]) acc_p1 <= acc_p1 + mul_a_p1;
      mul_a_p1 <= mul_a_p1 << 1;
      mul_b_p1 <= mul_b_p1 >> 1;
      cnt_p1   <= cnt_p1 + CNT_W'(1);
    end
  end
`else
  assign in_ready    = !rst && slot_free && !flush;
  assign accept      = in_valid && in_ready;
  assign load_single = accept;
  assign load_mul    = 1'b0;
  assign busy        = 1'b0;

  assign nxt_res = res_p0;
  assign nxt_wd  = rd2;
  assign nxt_m2r = mem_to_reg;
  assign nxt_mw  = mem_write;
  assign nxt_rw  = reg_write;
  assign nxt_pc  = pc_target;
`endif

  // EX/MEM slot: flush beats load, load beats consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      alu_result   <= '0;
      write_data   <= '0;
      zero         <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_target_q  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_single || load_mul) begin
      out_valid    <= 1'b1;
      alu_result   <= nxt_res;
      write_data   <= nxt_wd;
      zero         <= (nxt_res == '0);
      mem_to_reg_q <= nxt_m2r;
      mem_write_q  <= nxt_mw;
      reg_write_q  <= nxt_rw;
      pc_target_q  <= nxt_pc;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Testbench for ex_stage_unit: directed vectors, scoreboard queue, negedge monitor.
module tb_ex_stage_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        mem_to_reg;
  logic        mem_write;
  logic        reg_write;
  logic        alu_src;
  logic [4:0]  alu_control;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] sign_imm;
  logic [31:0] pc_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        zero;
  logic        mem_to_reg_q;
  logic        mem_write_q;
  logic        reg_write_q;
  logic [31:0] pc_target_q;
  logic        busy;

  ex_stage_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src(alu_src), .alu_control(alu_control),
    .rd1(rd1), .rd2(rd2), .sign_imm(sign_imm), .pc_target(pc_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .write_data(write_data), .zero(zero),
    .mem_to_reg_q(mem_to_reg_q), .mem_write_q(mem_write_q), .reg_write_q(reg_write_q),
    .pc_target_q(pc_target_q), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        zf;
    logic [31:0] wd;
    logic [2:0]  ctl;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   cyc;
  int   pass_cnt;
  int   total_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time output arrivals.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: every consumed slot is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        chk("alu_result", alu_result, e.res);
        chk("zero", {31'd0, zero}, {31'd0, e.zf});
        chk("write_data", write_data, e.wd);
        chk("controls", {29'd0, mem_to_reg_q, mem_write_q, reg_write_q}, {29'd0, e.ctl});
        chk("pc_target_q", pc_target_q, e.pc);
      end
    end
  end

  // Present one instruction, wait (bounded) for acceptance, optionally log expectation.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic [2:0] ctl,
                       input logic [31:0] pc, input logic [31:0] res, input bit push);
    bit got;
    alu_control = op; rd1 = a; rd2 = b; sign_imm = imm; alu_src = src;
    {mem_to_reg, mem_write, reg_write} = ctl; pc_target = pc;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        if (push) exp_q.push_back('{res: res, zf: (res == 32'd0), wd: b, ctl: ctl, pc: pc});
      end
      @(posedge clk); #1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    pass_cnt = 0; total_cnt = 0; cyc = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    alu_control = 5'b00000; rd1 = 32'd1; rd2 = 32'd2; sign_imm = 32'd3; alu_src = 1'b0;
    mem_to_reg = 1'b1; mem_write = 1'b1; reg_write = 1'b1; pc_target = 32'hDEAD_BEEF;

    // Reset held two cycles with a valid instruction offered.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_alu_result", alu_result, 32'd0);
    chk("rst_pc_q", pc_target_q, 32'd0);
    chk("rst_ctl", {29'd0, mem_to_reg_q, mem_write_q, reg_write_q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // ADD then SUB back to back, no bubble.
    n0 = pop_cyc.size();
    issue(5'b00000, 32'd5, 32'd7, 32'd0, 1'b0, 3'b001, 32'h0000_1000, 32'd12, 1);
    issue(5'b00001, 32'd3, 32'h77, 32'd5, 1'b1, 3'b110, 32'h0000_2000, 32'hFFFF_FFFE, 1);
    @(negedge clk); #1;
    if (pop_cyc.size() >= n0 + 2) chk("no_bubble", pop_cyc[n0+1] - pop_cyc[n0], 32'd1);
    else chk("no_bubble_count", pop_cyc.size() - n0, 32'd2);
    @(posedge clk); #1;

    // Back-pressure: result held, in_ready low, then accept on release.
    out_ready = 1'b0;
    issue(5'b00010, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 3'b011, 32'h0000_3000, 32'h0000_F000, 1);
    alu_control = 5'b00011; rd1 = 32'h0F00; rd2 = 32'h00F0; alu_src = 1'b0;
    {mem_to_reg, mem_write, reg_write} = 3'b100; pc_target = 32'h0000_4000;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_result", alu_result, 32'h0000_F000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back('{res: 32'h0FF0, zf: 1'b0, wd: 32'h00F0, ctl: 3'b100, pc: 32'h0000_4000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    settle();

    // Flush an occupied output slot.
    out_ready = 1'b0;
    issue(5'b00000, 32'd9, 32'd9, 32'd0, 1'b0, 3'b001, 32'h0000_5000, 32'd18, 0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    issue(5'b00000, 32'd1, 32'd1, 32'd0, 1'b0, 3'b001, 32'h0000_6000, 32'd2, 1);
    settle();

`ifdef EX_MUL_EN
    // Iterative MUL: busy 32 cycles, result at accept+34, in_ready low meanwhile.
    begin
      int bcnt; int lat; int irbad;
      bcnt = 0; lat = 0; irbad = 0;
      issue(5'b01010, 32'h0001_0000, 32'h0003_0001, 32'd0, 1'b0, 3'b001, 32'h0000_7000, 32'h0001_0000, 1);
      for (int k = 1; k <= 100 && lat == 0; k++) begin
        @(negedge clk);
        if (out_valid) lat = k;
        else begin
          if (busy) bcnt++;
          if (in_ready) irbad++;
        end
      end
      chk("mul_busy_cycles", bcnt, 32'd32);
      chk("mul_latency", lat, 32'd34);
      chk("mul_in_ready_low", irbad, 32'd0);
      @(posedge clk); #1;
      settle();
    end
    // Flush at iteration 10.
    issue(5'b01010, 32'd3, 32'd5, 32'd0, 1'b0, 3'b001, 32'h0000_8000, 32'd15, 0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("mulflush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("mulflush_busy", {31'd0, busy}, 32'd0);
    chk("mulflush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    issue(5'b00000, 32'd1, 32'd1, 32'd0, 1'b0, 3'b001, 32'h0000_9000, 32'd2, 1);
    settle();
`else
    // Without the multiplier, MUL is an unsupported code: result 0, latency 1.
    issue(5'b01010, 32'h0001_0000, 32'h0003_0001, 32'd0, 1'b0, 3'b001, 32'h0000_7000, 32'd0, 1);
    @(negedge clk);
    chk("nomul_busy", {31'd0, busy}, 32'd0);
    chk("nomul_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
`endif

    // Shifts, compares and an unsupported code.
    issue(5'b00111, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 3'b001, 32'h0000_A000, 32'hF800_0000, 1);
    issue(5'b00110, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 3'b001, 32'h0000_A004, 32'h0800_0000, 1);
    issue(5'b00101, 32'h0000_0003, 32'd8, 32'd0, 1'b0, 3'b010, 32'h0000_A008, 32'h0000_0300, 1);
    issue(5'b01000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b001, 32'h0000_A00C, 32'd1, 1);
    issue(5'b01001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b001, 32'h0000_A010, 32'd0, 1);
    issue(5'b00100, 32'h0000_00FF, 32'h0000_000F, 32'd0, 1'b0, 3'b101, 32'h0000_A014, 32'h0000_00F0, 1);
    issue(5'b11111, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0, 3'b111, 32'h0000_A018, 32'd0, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
